// File: rtl/ddr_rd_ctrl.sv
// DDR read command engine: splits one line-read request into AR bursts of at most
// MAX_BURST beats, forwards the returned beats and pulses rd_done when all have landed.
module ddr_rd_ctrl #(
  parameter int ADDR_WIDTH    = 27,
  parameter int DQ_WIDTH      = 32,
  parameter int LEN_WIDTH     = 16,
  parameter int MAX_BURST     = 64,
  parameter int BEAT_ADDR_INC = 8
) (
  input  logic                    ddr_clk,
  input  logic                    ddr_rst,
  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [LEN_WIDTH-1:0]    rd_len,
  output logic                    rd_rrdy,
  output logic                    rd_done,
  output logic                    rd_err,
  output logic [8*DQ_WIDTH-1:0]   rd_data,
  output logic                    rd_data_en,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [7:0]              axi_arlen,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [8*DQ_WIDTH-1:0]   axi_rdata,
  input  logic                    axi_rvalid,
  input  logic                    axi_rlast,
  output logic                    axi_rready
);

  localparam int BW = 8 * DQ_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BEAT_ADDR_INC);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]    remain_q, remain_d;
  logic [8:0]              beat_cnt_q, beat_cnt_d;
  logic [BW-1:0]           rd_data_q, rd_data_d;
  logic                    rd_data_en_q, rd_data_en_d;
  logic                    rd_done_q, rd_done_d;
  logic                    rd_err_q, rd_err_d;
  logic [8:0]              burst;
  logic                    last_beat;

  // burst holds up to 256, so it needs 9 bits even though arlen is 8
  assign burst = (32'(remain_q) > MAX_BURST) ? 9'(MAX_BURST) : 9'(remain_q);
  assign last_beat = (beat_cnt_q == 9'd1);

  assign rd_rrdy     = (state_q == IDLE);
  assign axi_arvalid = (state_q == ADDR);
  assign axi_rready  = (state_q == DATA);
  assign axi_araddr  = (state_q == ADDR) ? cur_addr_q : '0;
  assign axi_arlen   = (state_q == ADDR) ? 8'(burst - 9'd1) : 8'd0;
  assign rd_data     = rd_data_q;
  assign rd_data_en  = rd_data_en_q;
  assign rd_done     = rd_done_q;
  assign rd_err      = rd_err_q;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remain_d     = remain_q;
    beat_cnt_d   = beat_cnt_q;
    rd_done_d    = 1'b0;
    rd_err_d     = rd_req && (state_q != IDLE);
    rd_data_en_d = axi_rvalid && axi_rready;
    rd_data_d    = rd_data_en_d ? axi_rdata : rd_data_q;

    case (state_q)
      IDLE: begin
        if (rd_req) begin
          if (rd_len == '0) begin
            state_d = FIN;
          end else begin
            cur_addr_d = rd_addr;
            remain_d   = rd_len;
            state_d    = ADDR;
          end
        end
      end
      ADDR: begin
        if (axi_arready) begin
          beat_cnt_d = burst;
          cur_addr_d = cur_addr_q + ADDR_WIDTH'(burst) * ADDR_STEP;
          remain_d   = remain_q - LEN_WIDTH'(burst);
          state_d    = DATA;
        end
      end
      DATA: begin
        if (axi_rvalid) begin
          beat_cnt_d = beat_cnt_q - 9'd1;
          // rlast disagreeing with our own count is flagged but never trusted
          if (axi_rlast != last_beat) rd_err_d = 1'b1;
          if (last_beat) state_d = (remain_q != '0) ? ADDR : FIN;
        end
      end
      FIN: begin
        rd_done_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ddr_clk or posedge ddr_rst) begin
    if (ddr_rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      remain_q     <= '0;
      beat_cnt_q   <= '0;
      rd_data_q    <= '0;
      rd_data_en_q <= 1'b0;
      rd_done_q    <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remain_q     <= remain_d;
      beat_cnt_q   <= beat_cnt_d;
      rd_data_q    <= rd_data_d;
      rd_data_en_q <= rd_data_en_d;
      rd_done_q    <= rd_done_d;
      rd_err_q     <= rd_err_d;
    end
  end

endmodule
